multi_cycle_control: RTL and testbench

Multi-cycle control FSM that replaces the single-cycle main decoder when the CPU datapath is converted to a shared-memory, shared-ALU multi-cycle design. It sequences instruction fetch, decode, execute, memory and write-back over 3–5 cycles per instruction. It stalls on a memory ready handshake and drives every datapath mux select and write enable. ALU function selection for R-type stays with the existing ALU control decoder, which is fed by `ALUop` from this block.

---
 rtl/mips_defs.sv | 68 ++++++
 rtl/multi_cycle_control_if.sv | 37 +++
 rtl/mc_output_decode.sv | 98 +++++++++
 rtl/multi_cycle_control.sv | 77 +++++++
 tb/tb_multi_cycle_control.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle CPU: opcodes, ALU op codes, mux selects and FSM states.
// The main control decoder and the ALU control decoder import the same constants.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // 3'b011 is reserved and must never be driven
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_OR    = 3'b010;
   localparam logic [2:0] ALUOP_RTYPE = 3'b100;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_I_EXEC    = 4'd10,
      S_I_WB      = 4'd11
   } state_t;

   typedef struct packed {
      logic       PCWrite;
      logic       PCWriteCond;
      logic       IorD;
      logic       memRead;
      logic       memWrite;
      logic       IRWrite;
      logic       memToReg;
      logic       regWrite;
      logic       regDst;
      logic       ALUSrcA;
      logic       extop;
      logic [1:0] PCSource;
      logic [1:0] ALUSrcB;
      logic [2:0] ALUop;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic op_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: op_supported = 1'b1;
         default:                                       op_supported = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
interface multi_cycle_control_if;
   logic [5:0] OP;
   logic       zero;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       memRead;
   logic       memWrite;
   logic       IRWrite;
   logic       memToReg;
   logic       regWrite;
   logic       regDst;
   logic       ALUSrcA;
   logic       extop;
   logic [1:0] PCSource;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUop;
   logic [3:0] state;
   logic       instr_done;
   logic       illegal_op;

   modport master (
      input  OP, zero, mem_ready,
      output PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite, memToReg,
             regWrite, regDst, ALUSrcA, extop, PCSource, ALUSrcB, ALUop,
             state, instr_done, illegal_op
   );

   modport slave (
      output OP, zero, mem_ready,
      input  PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite, memToReg,
             regWrite, regDst, ALUSrcA, extop, PCSource, ALUSrcB, ALUop,
             state, instr_done, illegal_op
   );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational control-output decode from the current state, mem_ready and (in DECODE) the opcode.
// Reset gates every write enable and the completion/illegal pulses.
module mc_output_decode
   import mips_defs::*;
(
   input  logic       rst_i,
   input  state_t     state_i,
   input  logic       mem_ready_i,
   input  logic [5:0] op_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.memRead  = 1'b1;
            ctrl_o.ALUSrcB  = SRCB_FOUR;
            ctrl_o.ALUop    = ALUOP_ADD;
            ctrl_o.PCSource = PCSRC_ALU;
            ctrl_o.IRWrite  = mem_ready_i;
            ctrl_o.PCWrite  = mem_ready_i;
         end
         S_DECODE: begin
            // branch target is precomputed here and parked in ALUOut
            ctrl_o.ALUSrcB    = SRCB_IMM_SH2;
            ctrl_o.ALUop      = ALUOP_ADD;
            ctrl_o.extop      = 1'b1;
            ctrl_o.illegal_op = !op_supported(op_i);
            ctrl_o.instr_done = !op_supported(op_i);
         end
         S_MEM_ADDR: begin
            ctrl_o.ALUSrcA = 1'b1;
            ctrl_o.ALUSrcB = SRCB_IMM;
            ctrl_o.ALUop   = ALUOP_ADD;
            ctrl_o.extop   = 1'b1;
         end
         S_MEM_READ: begin
            ctrl_o.memRead = 1'b1;
            ctrl_o.IorD    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_o.regWrite   = 1'b1;
            ctrl_o.memToReg   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl_o.IorD       = 1'b1;
            ctrl_o.memWrite   = 1'b1;
            ctrl_o.instr_done = mem_ready_i;
         end
         S_R_EXEC: begin
            ctrl_o.ALUSrcA = 1'b1;
            ctrl_o.ALUSrcB = SRCB_REG;
            ctrl_o.ALUop   = ALUOP_RTYPE;
         end
         S_R_WB: begin
            ctrl_o.regWrite   = 1'b1;
            ctrl_o.regDst     = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_I_EXEC: begin
            ctrl_o.ALUSrcA = 1'b1;
            ctrl_o.ALUSrcB = SRCB_IMM;
            ctrl_o.ALUop   = ALUOP_OR;
         end
         S_I_WB: begin
            ctrl_o.regWrite   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.ALUSrcA     = 1'b1;
            ctrl_o.ALUSrcB     = SRCB_REG;
            ctrl_o.ALUop       = ALUOP_SUB;
            ctrl_o.PCWriteCond = 1'b1;
            ctrl_o.PCSource    = PCSRC_ALUOUT;
            ctrl_o.instr_done  = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.PCWrite    = 1'b1;
            ctrl_o.PCSource   = PCSRC_JUMP;
            ctrl_o.instr_done = 1'b1;
         end
         default: ctrl_o = '0;
      endcase

      if (rst_i) begin
         ctrl_o.PCWrite     = 1'b0;
         ctrl_o.PCWriteCond = 1'b0;
         ctrl_o.IRWrite     = 1'b0;
         ctrl_o.regWrite    = 1'b0;
         ctrl_o.memWrite    = 1'b0;
         ctrl_o.instr_done  = 1'b0;
         ctrl_o.illegal_op  = 1'b0;
      end
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU main control: state register, opcode latch and next-state sequencing.
// Outputs are decoded combinationally in mc_output_decode.
module multi_cycle_control
   import mips_defs::*;
(
   input logic                   clk,
   input logic                   rst,
   multi_cycle_control_if.master bus
);

   state_t     state_q, state_d;
   logic [5:0] op_q, op_d;
   ctrl_t      ctrl;

   always_comb begin
      state_d = S_FETCH;
      op_d    = op_q;
      case (state_q)
         S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            op_d = bus.OP;
            case (bus.OP)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ORI:       state_d = S_I_EXEC;
               default:      state_d = S_FETCH;
            endcase
         end
         // only lw/sw reach MEM_ADDR, so anything but lw is a store
         S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    state_d = S_R_WB;
         S_I_EXEC:    state_d = S_I_WB;
         default:     state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         op_q    <= 6'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   mc_output_decode u_decode (
      .rst_i       (rst),
      .state_i     (state_q),
      .mem_ready_i (bus.mem_ready),
      .op_i        (bus.OP),
      .ctrl_o      (ctrl)
   );

   assign bus.PCWrite     = ctrl.PCWrite;
   assign bus.PCWriteCond = ctrl.PCWriteCond;
   assign bus.IorD        = ctrl.IorD;
   assign bus.memRead     = ctrl.memRead;
   assign bus.memWrite    = ctrl.memWrite;
   assign bus.IRWrite     = ctrl.IRWrite;
   assign bus.memToReg    = ctrl.memToReg;
   assign bus.regWrite    = ctrl.regWrite;
   assign bus.regDst      = ctrl.regDst;
   assign bus.ALUSrcA     = ctrl.ALUSrcA;
   assign bus.extop       = ctrl.extop;
   assign bus.PCSource    = ctrl.PCSource;
   assign bus.ALUSrcB     = ctrl.ALUSrcB;
   assign bus.ALUop       = ctrl.ALUop;
   assign bus.instr_done  = ctrl.instr_done;
   assign bus.illegal_op  = ctrl.illegal_op;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: per-instruction state paths and control outputs
// are predicted from opcode, ready pattern and the per-state output table.
module tb_multi_cycle_control;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multi_cycle_control_if bus_if ();

   multi_cycle_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [5:0] legal_ops [6] = '{6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
   endfunction

   // order: PCWrite PCWriteCond IorD memRead memWrite IRWrite memToReg regWrite regDst ALUSrcA extop
   //        PCSource[2] ALUSrcB[2] ALUop[3] instr_done illegal_op
   function automatic logic [19:0] observed();
      return {bus_if.PCWrite, bus_if.PCWriteCond, bus_if.IorD, bus_if.memRead, bus_if.memWrite,
              bus_if.IRWrite, bus_if.memToReg, bus_if.regWrite, bus_if.regDst, bus_if.ALUSrcA,
              bus_if.extop, bus_if.PCSource, bus_if.ALUSrcB, bus_if.ALUop,
              bus_if.instr_done, bus_if.illegal_op};
   endfunction

   function automatic logic [19:0] expected(input int st, input logic rdy, input logic [5:0] op);
      logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rw = 0, rdst = 0;
      logic asa = 0, ext = 0, done = 0, ill = 0;
      logic [1:0] pcs = 2'b00, asb = 2'b00;
      logic [2:0] aop = 3'b000;
      case (st)
         0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
         1:  begin asb = 2'b11; ext = 1; ill = !is_legal(op); done = !is_legal(op); end
         2:  begin asa = 1; asb = 2'b10; ext = 1; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; done = 1; end
         5:  begin iord = 1; mwr = 1; done = rdy; end
         6:  begin asa = 1; aop = 3'b100; end
         7:  begin rw = 1; rdst = 1; done = 1; end
         8:  begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; done = 1; end
         9:  begin pcw = 1; pcs = 2'b10; done = 1; end
         10: begin asa = 1; asb = 2'b10; aop = 3'b010; end
         11: begin rw = 1; done = 1; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, asa, ext, pcs, asb, aop, done, ill};
   endfunction

   // mode 0: always ready; mode 1: random ready; mode 2: memory data phase waits 3 cycles
   task automatic run_instr(input logic [5:0] op, input int mode, output int mw_cycles);
      int   path[$];
      int   idx = 0, cyc = 0, mem_cnt = 0, done_cnt = 0, cur;
      logic rdy;
      mw_cycles = 0;
      path.push_back(0);
      path.push_back(1);
      case (op)
         6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
         6'b101011: begin path.push_back(2); path.push_back(5); end
         6'b000000: begin path.push_back(6); path.push_back(7); end
         6'b001101: begin path.push_back(10); path.push_back(11); end
         6'b000100: path.push_back(8);
         6'b000010: path.push_back(9);
         default: ;
      endcase
      while (idx < path.size() && cyc < 100) begin
         cur = path[idx];
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 2) != 0);
            default: rdy = (cur == 3 || cur == 5) ? (mem_cnt >= 3) : 1'b1;
         endcase
         if (cur == 3 || cur == 5) mem_cnt++;
         bus_if.mem_ready = rdy;
         bus_if.OP        = (cur == 1) ? op : 6'($urandom);
         bus_if.zero      = 1'($urandom);
         @(negedge clk);
         check($sformatf("state op=%b cyc=%0d", op, cyc), 32'(bus_if.state), 32'(cur));
         check($sformatf("outputs op=%b st=%0d rdy=%b", op, cur, rdy), 32'(observed()),
               32'(expected(cur, rdy, op)));
         if (bus_if.instr_done) done_cnt++;
         if (bus_if.memWrite) mw_cycles++;
         cyc++;
         if (!((cur == 0 || cur == 3 || cur == 5) && !rdy)) idx++;
         @(posedge clk);
         #1;
      end
      check($sformatf("instr_done count op=%b", op), 32'(done_cnt), 32'd1);
      check($sformatf("path completed op=%b", op), 32'(idx), 32'(path.size()));
   endtask

   initial begin
      int mw;
      rst              = 1'b1;
      bus_if.OP        = 6'b000000;
      bus_if.mem_ready = 1'b1;
      bus_if.zero      = 1'b0;
      #1;
      check("reset state", 32'(bus_if.state), 32'd0);
      check("reset outputs", 32'(observed()), 32'(expected(0, 1'b0, 6'd0)));
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus_if.mem_ready = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("fetch holds without ready", 32'(bus_if.state), 32'd0);

      run_instr(6'b100011, 0, mw);
      run_instr(6'b101011, 2, mw);
      check("sw memWrite cycles", 32'(mw), 32'd4);
      run_instr(6'b000100, 0, mw);
      run_instr(6'b000100, 0, mw);
      run_instr(6'b000000, 0, mw);
      run_instr(6'b001101, 0, mw);
      run_instr(6'b000010, 0, mw);
      run_instr(6'b111111, 0, mw);
      run_instr(6'b100011, 2, mw);

      // asynchronous reset while in MEM_WB
      bus_if.mem_ready = 1'b1;
      bus_if.OP        = 6'b100011;
      repeat (4) @(posedge clk);
      #1;
      check("pre-reset state MEM_WB", 32'(bus_if.state), 32'd4);
      check("pre-reset regWrite", 32'(bus_if.regWrite), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("async reset state", 32'(bus_if.state), 32'd0);
      check("async reset regWrite", 32'(bus_if.regWrite), 32'd0);
      check("async reset outputs", 32'(observed()), 32'(expected(0, 1'b0, 6'd0)));
      @(negedge clk);
      bus_if.mem_ready = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post-reset state", 32'(bus_if.state), 32'd0);

      for (int i = 0; i < 40; i++) begin
         int k = $urandom_range(0, 7);
         logic [5:0] op = (k < 6) ? legal_ops[k] : 6'($urandom);
         run_instr(op, 1, mw);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
